delta_ctrl: RTL and testbench
=============================

Name: delta_ctrl

Overview:
Microprogrammed sequencer that drives the select inputs of the LSTM backward-pass delta datapath. For each neuron element it replays a loadable per-step control program and addresses the gate/state memories. It issues write strobes when the datapath's o_dgate or o_d_state result is ready. It sits between the backprop top-level FSM (start/done handshake) and the delta datapath plus its operand/result memories.

Parameters:
ADDR_WIDTH, 8, element address width (rd_addr/wr_addr/n_elem)
STEPS, 12, depth of the microprogram store (max steps per element)
PROG_AW, 4, microprogram address and length width
CW, 25, control word width (fixed layout below)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE without done
n_elem  input  ADDR_WIDTH  number of elements to process; sampled with start
prog_len  input  PROG_AW  steps per element; sampled with start
prog_we  input  1  microprogram write enable
prog_addr  input  PROG_AW  microprogram write address
prog_data  input  CW  microprogram write data
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
rd_addr  output  ADDR_WIDTH  operand memory element index
wr_addr  output  ADDR_WIDTH  result memory element index
wr_dgate_en  output  1  write o_dgate to result memory
wr_dstate_en  output  1  write o_d_state to result memory
wr_gate_id  output  2  gate slot for the dgate write (0=a,1=i,2=f,3=o)
sel_in1, sel_in2, sel_in4, sel_x1_1, sel_x2_2, sel_as_2, sel_temp  output  2 each  datapath selects
sel_in3, sel_x1_2, sel_as_1, sel_addsub  output  1 each  datapath selects
sel_in5  output  3  datapath select

Behaviour:
- Clock clk, reset rst: asynchronous, active-high. On reset: state IDLE, all microprogram words 0, elem=0, step=0, and every output 0.
- Control word layout (bit ranges):
  - [1:0] sel_in1, [3:2] sel_in2, [4] sel_in3, [6:5] sel_in4, [9:7] sel_in5
  - [11:10] sel_x1_1, [12] sel_x1_2, [14:13] sel_x2_2, [15] sel_as_1, [17:16] sel_as_2
  - [18] sel_addsub, [20:19] sel_temp, [21] dgate strobe, [22] dstate strobe, [24:23] gate id
- Microprogram store:
  - Written on the clk edge when prog_we=1, state is IDLE and prog_addr<STEPS.
  - Writes are ignored in RUN/DONE and when prog_addr>=STEPS.
- States: IDLE, RUN, DONE.
- IDLE:
  - All outputs 0.
  - On start: eff_len = min(prog_len, STEPS).
  - If n_elem=0 or eff_len=0: go to DONE (no RUN cycles).
  - Otherwise latch n_elem and eff_len, clear elem and step, go to RUN.
- RUN:
  - All select outputs, and wr_gate_id, are decoded combinationally from prog[step].
  - wr_dgate_en = bit21; wr_dstate_en = bit22.
  - rd_addr = wr_addr = elem; busy=1.
  - Each cycle: if step != eff_len-1, step++. Otherwise step=0 and elem++.
  - On the last step of element n_elem-1: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, all selects 0, then IDLE.
- Latency and strobe timing:
  - start sampled at edge k: prog[0] is visible after edge k.
  - busy is high for exactly n_elem*eff_len cycles; done follows in the next cycle.
- Strobes are emitted exactly as programmed. The microprogram author places them on the step where the datapath register holds the result.
- Boundary conditions:
  - start during RUN/DONE: ignored.
  - abort in RUN: next state IDLE, no done pulse, elem/step cleared. abort has priority over step advance and over start.
  - abort in IDLE/DONE: no effect.
  - n_elem and prog_len changing during RUN: no effect (latched values are used).
  - Reset mid-run: immediate IDLE, program cleared.

Test Plan:
- Reset, write prog[0]=0x0000003, prog[1]=0x0A00000, prog_len=2, n_elem=3, start -> busy high 6 cycles; sel_in1 sequence 3,0,3,0,3,0; wr_dgate_en and wr_gate_id=1 on cycles 2,4,6; rd_addr 0,0,1,1,2,2; done pulse on cycle 7.
- Start with n_elem=0 (prog_len=4) -> busy never high, done pulses once the cycle after start.
- prog_len=15 with STEPS=12 -> each element spans 12 cycles; n_elem=2 gives busy for 24 cycles.
- prog_we during RUN to prog[0]=0x1FFFFFF -> program unchanged; the second element replays the original word 0x0000003.
- abort asserted on cycle 3 of a 6-cycle run -> busy drops the next cycle, no done pulse; a new start restarts at rd_addr=0.
- rst asserted mid-run -> all outputs 0 immediately; prog reads back as 0 on the next run (all selects 0).

Source files
------------

// File: rtl/delta_ctrl.sv
// delta_ctrl: microprogrammed sequencer for the LSTM backward-pass delta datapath.
// Replays prog[0..eff_len-1] once per element and walks the element index.
module delta_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int STEPS      = 12,
  parameter int PROG_AW    = 4,
  parameter int CW         = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] n_elem,
  input  logic [PROG_AW-1:0]    prog_len,
  input  logic                  prog_we,
  input  logic [PROG_AW-1:0]    prog_addr,
  input  logic [CW-1:0]         prog_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_dgate_en,
  output logic                  wr_dstate_en,
  output logic [1:0]            wr_gate_id,
  output logic [1:0]            sel_in1,
  output logic [1:0]            sel_in2,
  output logic                  sel_in3,
  output logic [1:0]            sel_in4,
  output logic [2:0]            sel_in5,
  output logic [1:0]            sel_x1_1,
  output logic                  sel_x1_2,
  output logic [1:0]            sel_x2_2,
  output logic                  sel_as_1,
  output logic [1:0]            sel_as_2,
  output logic                  sel_addsub,
  output logic [1:0]            sel_temp
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [PROG_AW-1:0] STEPS_W = PROG_AW'(STEPS);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_prog [STEPS];
  logic [ADDR_WIDTH-1:0] r_elem;
  logic [ADDR_WIDTH-1:0] r_n_elem;
  logic [PROG_AW-1:0]    r_step;
  logic [PROG_AW-1:0]    r_len;
  logic [PROG_AW-1:0]    w_eff_len;
  logic                  w_last_step;
  logic                  w_last_elem;
  logic                  w_run;
  logic [CW-1:0]         w_word;

  assign w_eff_len   = (prog_len > STEPS_W) ? STEPS_W : prog_len;
  assign w_last_step = (r_step == r_len - PROG_AW'(1));
  assign w_last_elem = (r_elem == r_n_elem - ADDR_WIDTH'(1));
  assign w_run       = (r_state == S_RUN);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (n_elem == '0 || w_eff_len == '0) w_next = S_DONE;
          else                                 w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)                           w_next = S_IDLE;
        else if (w_last_step && w_last_elem) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_elem   <= '0;
      r_step   <= '0;
      r_n_elem <= '0;
      r_len    <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_next == S_RUN) begin
            r_n_elem <= n_elem;
            r_len    <= w_eff_len;
            r_elem   <= '0;
            r_step   <= '0;
          end
        end
        S_RUN: begin
          if (w_next != S_RUN) begin
            r_elem <= '0;
            r_step <= '0;
          end else if (w_last_step) begin
            r_step <= '0;
            r_elem <= r_elem + ADDR_WIDTH'(1);
          end else begin
            r_step <= r_step + PROG_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Program store is only writable while the sequencer is parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) r_prog[i] <= '0;
    end else if (prog_we && r_state == S_IDLE && prog_addr < STEPS_W) begin
      r_prog[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    w_word = '0;
    if (w_run) w_word = r_prog[r_step];
  end

  assign busy         = w_run;
  assign done         = (r_state == S_DONE);
  assign rd_addr      = w_run ? r_elem : '0;
  assign wr_addr      = w_run ? r_elem : '0;
  assign sel_in1      = w_word[1:0];
  assign sel_in2      = w_word[3:2];
  assign sel_in3      = w_word[4];
  assign sel_in4      = w_word[6:5];
  assign sel_in5      = w_word[9:7];
  assign sel_x1_1     = w_word[11:10];
  assign sel_x1_2     = w_word[12];
  assign sel_x2_2     = w_word[14:13];
  assign sel_as_1     = w_word[15];
  assign sel_as_2     = w_word[17:16];
  assign sel_addsub   = w_word[18];
  assign sel_temp     = w_word[20:19];
  assign wr_dgate_en  = w_word[21];
  assign wr_dstate_en = w_word[22];
  assign wr_gate_id   = w_word[24:23];

endmodule

// File: tb/tb_delta_ctrl.sv
// tb_delta_ctrl: randomized and directed checks of delta_ctrl against
// a program-replay reference model held in the bench.
module tb_delta_ctrl;

  localparam int STEPS = 12;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic        abort = 0;
  logic [7:0]  n_elem = 0;
  logic [3:0]  prog_len = 0;
  logic        prog_we = 0;
  logic [3:0]  prog_addr = 0;
  logic [24:0] prog_data = 0;
  logic        busy, done;
  logic [7:0]  rd_addr, wr_addr;
  logic        wr_dgate_en, wr_dstate_en;
  logic [1:0]  wr_gate_id;
  logic [1:0]  sel_in1, sel_in2, sel_in4, sel_x1_1, sel_x2_2, sel_as_2, sel_temp;
  logic        sel_in3, sel_x1_2, sel_as_1, sel_addsub;
  logic [2:0]  sel_in5;

  logic [24:0] m_prog [STEPS];
  int n_pass = 0;
  int n_total = 0;

  delta_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_elem(n_elem), .prog_len(prog_len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy), .done(done), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_dgate_en(wr_dgate_en), .wr_dstate_en(wr_dstate_en),
    .wr_gate_id(wr_gate_id),
    .sel_in1(sel_in1), .sel_in2(sel_in2), .sel_in3(sel_in3),
    .sel_in4(sel_in4), .sel_in5(sel_in5),
    .sel_x1_1(sel_x1_1), .sel_x1_2(sel_x1_2), .sel_x2_2(sel_x2_2),
    .sel_as_1(sel_as_1), .sel_as_2(sel_as_2),
    .sel_addsub(sel_addsub), .sel_temp(sel_temp)
  );

  always #5 clk = ~clk;

  // Reassemble the observed control fields into the programmed word layout.
  function automatic logic [24:0] got_word();
    return {wr_gate_id, wr_dstate_en, wr_dgate_en, sel_temp, sel_addsub,
            sel_as_2, sel_as_1, sel_x2_2, sel_x1_2, sel_x1_1,
            sel_in5, sel_in4, sel_in3, sel_in2, sel_in1};
  endfunction

  function automatic int eff_of(input int len);
    return (len > STEPS) ? STEPS : len;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [24:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
    if (a < STEPS) m_prog[a] = d;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [3:0] len);
    start = 1; n_elem = n; prog_len = len;
    tick();
    start = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    rst = 0;
    for (int i = 0; i < STEPS; i++) m_prog[i] = '0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({busy, done, rd_addr, wr_addr, got_word()} !== '0)
      $display("FAIL reset_outputs busy=%b done=%b rd=%0d wr=%0d word=%h want all 0",
               busy, done, rd_addr, wr_addr, got_word());
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [1:0] exp_in1;
    prog_write(4'd0, 25'h0000003);
    prog_write(4'd1, 25'h0A00000);
    do_start(8'd3, 4'd2);
    for (int c = 1; c <= 6; c++) begin
      exp_in1 = (c % 2 == 1) ? 2'd3 : 2'd0;
      n_total++;
      if (busy !== 1'b1 || sel_in1 !== exp_in1 || rd_addr !== 8'((c - 1) / 2)
          || wr_addr !== 8'((c - 1) / 2) || wr_dgate_en !== (c % 2 == 0)
          || wr_gate_id !== ((c % 2 == 0) ? 2'd1 : 2'd0) || done !== 1'b0)
        $display("FAIL basic_c%0d busy=%b in1=%0d rd=%0d dg=%b gid=%0d want in1=%0d rd=%0d",
                 c, busy, sel_in1, rd_addr, wr_dgate_en, wr_gate_id, exp_in1, (c - 1) / 2);
      else n_pass++;
      tick();
    end
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || got_word() !== '0)
      $display("FAIL basic_done done=%b busy=%b word=%h want 1 0 0", done, busy, got_word());
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL basic_done_once done=%b want 0", done);
    else n_pass++;
  endtask

  task automatic test_zero();
    do_start(8'd0, 4'd4);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_n done=%b busy=%b want 1 0", done, busy);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_n_after done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
    do_start(8'd3, 4'd0);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_len done=%b busy=%b want 1 0", done, busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    int busy_cnt = 0;
    int bad = 0;
    for (int i = 0; i < STEPS; i++) prog_write(4'(i), 25'($urandom));
    do_start(8'd2, 4'd15);
    for (int c = 0; c < 30 && busy === 1'b1; c++) begin
      if (got_word() !== m_prog[busy_cnt % STEPS] || rd_addr !== 8'(busy_cnt / STEPS))
        bad++;
      busy_cnt++;
      tick();
    end
    n_total++;
    if (busy_cnt != 24 || bad != 0)
      $display("FAIL clamp busy_cycles=%0d bad_words=%0d want 24 0", busy_cnt, bad);
    else n_pass++;
    n_total++;
    if (done !== 1'b1) $display("FAIL clamp_done done=%b want 1", done);
    else n_pass++;
    tick();
  endtask

  task automatic test_prog_we_run();
    prog_write(4'd0, 25'h0000003);
    prog_write(4'd1, 25'h0A00000);
    do_start(8'd3, 4'd2);
    prog_we = 1; prog_addr = 4'd0; prog_data = 25'h1FFFFFF;
    for (int c = 0; c < 6; c++) begin
      n_total++;
      if (got_word() !== m_prog[c % 2] || busy !== 1'b1)
        $display("FAIL prog_we_run_c%0d word=%h busy=%b want %h 1",
                 c, got_word(), busy, m_prog[c % 2]);
      else n_pass++;
      tick();
    end
    prog_we = 0;
    n_total++;
    if (done !== 1'b1) $display("FAIL prog_we_run_done done=%b want 1", done);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    do_start(8'd3, 4'd2);
    for (int c = 1; c <= 3; c++) begin
      n_total++;
      if (busy !== 1'b1 || rd_addr !== 8'((c - 1) / 2))
        $display("FAIL abort_pre_c%0d busy=%b rd=%0d want 1 %0d", c, busy, rd_addr, (c - 1) / 2);
      else n_pass++;
      if (c == 3) begin
        abort = 1; start = 1;
      end
      tick();
    end
    abort = 0; start = 0;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL abort_post_c%0d busy=%b done=%b want 0 0", c, busy, done);
      else n_pass++;
      tick();
    end
    do_start(8'd3, 4'd2);
    n_total++;
    if (busy !== 1'b1 || rd_addr !== 8'd0 || got_word() !== m_prog[0])
      $display("FAIL abort_restart busy=%b rd=%0d word=%h want 1 0 %h",
               busy, rd_addr, got_word(), m_prog[0]);
    else n_pass++;
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_random();
    int n, eff, len;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < STEPS; i++) prog_write(4'(i), 25'($urandom));
      n   = $urandom_range(1, 4);
      len = $urandom_range(1, 15);
      eff = eff_of(len);
      abort = 1'($urandom_range(0, 1));
      do_start(8'(n), 4'(len));
      abort = 0;
      for (int e = 0; e < n; e++) begin
        for (int s = 0; s < eff; s++) begin
          n_total++;
          if (busy !== 1'b1 || done !== 1'b0 || got_word() !== m_prog[s]
              || rd_addr !== 8'(e) || wr_addr !== 8'(e))
            $display("FAIL rand_r%0d_e%0d_s%0d busy=%b word=%h rd=%0d want %h rd=%0d",
                     r, e, s, busy, got_word(), rd_addr, m_prog[s], e);
          else n_pass++;
          start = 1'($urandom_range(0, 1));
          n_elem = 8'($urandom);
          prog_len = 4'($urandom);
          prog_we = 1'($urandom_range(0, 1));
          prog_addr = 4'($urandom_range(0, 11));
          prog_data = 25'($urandom);
          tick();
        end
      end
      start = 0; prog_we = 0;
      abort = 1;
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0)
        $display("FAIL rand_done_r%0d done=%b busy=%b want 1 0", r, done, busy);
      else n_pass++;
      tick();
      abort = 0;
    end
  endtask

  task automatic test_rst_mid();
    prog_write(4'd0, 25'h1555555);
    prog_write(4'd1, 25'h0AAAAAA);
    do_start(8'd4, 4'd2);
    tick();
    tick();
    rst = 1;
    #1;
    n_total++;
    if ({busy, done, rd_addr, wr_addr, got_word()} !== '0)
      $display("FAIL rst_mid busy=%b done=%b rd=%0d word=%h want all 0",
               busy, done, rd_addr, got_word());
    else n_pass++;
    rst = 0;
    for (int i = 0; i < STEPS; i++) m_prog[i] = '0;
    tick();
    do_start(8'd1, 4'd3);
    for (int s = 0; s < 3; s++) begin
      n_total++;
      if (busy !== 1'b1 || got_word() !== m_prog[s])
        $display("FAIL rst_prog_cleared_s%0d busy=%b word=%h want 1 %h",
                 s, busy, got_word(), m_prog[s]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL rst_rerun_done done=%b want 1", done);
    else n_pass++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) m_prog[i] = '0;
    tick();
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_prog_we_run();
    test_abort();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
